// File: rtl/fft16_bf_sequencer.sv
// In-place 16-point radix-2 FFT sequencer: bit-reversed load, 4x8 butterflies, natural-order unload.
// Optional FFT_STAGE_SCALE_EN halves every stored butterfly result (total 1/16).
module fft16_bf_sequencer #(
    parameter int N = 16,
    parameter int Q = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_in_re,
    input  logic [N-1:0] i_in_im,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    output logic [N-1:0] o_bf_in0_re,
    output logic [N-1:0] o_bf_in0_im,
    output logic [N-1:0] o_bf_in1_re,
    output logic [N-1:0] o_bf_in1_im,
    output logic [N-1:0] o_bf_tw_re,
    output logic [N-1:0] o_bf_tw_im,
    output logic         o_bf_start,
    input  logic [N-1:0] i_bf_out0_re,
    input  logic [N-1:0] i_bf_out0_im,
    input  logic [N-1:0] i_bf_out1_re,
    input  logic [N-1:0] i_bf_out1_im,
    input  logic         i_bf_done,
    output logic [N-1:0] o_out_re,
    output logic [N-1:0] o_out_im,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic         o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_UNLOAD
    } state_t;

    localparam logic [N-1:0] ONE = N'(1 << Q);

    function automatic logic [3:0] bitrev4(input logic [3:0] n);
        return {n[0], n[1], n[2], n[3]};
    endfunction

    function automatic logic [3:0] calc_idx0(input logic [1:0] s,
                                             input logic [2:0] b);
        logic [3:0] half;
        logic [3:0] pos;
        logic [3:0] grp;
        half = 4'd1 << s;
        pos  = {1'b0, b} & (half - 4'd1);
        grp  = {1'b0, b} >> s;
        return (grp << ({1'b0, s} + 3'd1)) + pos;
    endfunction

    function automatic logic [2:0] calc_k(input logic [1:0] s,
                                          input logic [2:0] b);
        logic [3:0] hm;
        logic [2:0] pos;
        hm  = (4'd1 << s) - 4'd1;
        pos = b & hm[2:0];
        return pos << (2'd3 - s);
    endfunction

    // W16^k, Q8.8: {re, im}
    function automatic logic [2*N-1:0] tw_rom(input logic [2:0] k);
        logic [N-1:0] re;
        logic [N-1:0] im;
        unique case (k)
            3'd0: begin re = ONE;      im = N'(0);    end
            3'd1: begin re = N'(237);  im = N'(-98);  end
            3'd2: begin re = N'(181);  im = N'(-181); end
            3'd3: begin re = N'(98);   im = N'(-237); end
            3'd4: begin re = N'(0);    im = -ONE;     end
            3'd5: begin re = N'(-98);  im = N'(-237); end
            3'd6: begin re = N'(-181); im = N'(-181); end
            3'd7: begin re = N'(-237); im = N'(-98);  end
        endcase
        return {re, im};
    endfunction

    function automatic logic [N-1:0] scl(input logic [N-1:0] v);
`ifdef FFT_STAGE_SCALE_EN
        return $signed(v) >>> 1;
`else
        return v;
`endif
    endfunction

    state_t       state;
    state_t       next_state;
    logic [2*N-1:0] mem [16];

    logic [3:0] in_cnt;
    logic [3:0] out_idx;
    logic [3:0] out_idx_n;
    logic [1:0] s_q;
    logic [1:0] s_n;
    logic [2:0] b_q;
    logic [2:0] b_n;
    logic [3:0] idx0_q;
    logic [3:0] idx1_q;
    logic [3:0] idx0_n;
    logic [3:0] idx1_n;
    logic [2:0] k_n;

    logic [N-1:0] res0_re;
    logic [N-1:0] res0_im;
    logic [N-1:0] res1_re;
    logic [N-1:0] res1_im;

    logic in_fire;
    logic out_fire;
    logic in_ready_n;
    logic busy_n;
    logic start_n;
    logic valid_n;

    assign in_fire  = i_in_valid & o_in_ready;
    assign out_fire = o_out_valid & i_out_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        s_n        = s_q;
        b_n        = b_q;
        unique case (state)
            S_IDLE: begin
                if (in_fire) next_state = S_LOAD;
            end
            S_LOAD: begin
                if (in_fire && in_cnt == 4'd15) begin
                    next_state = S_ISSUE;
                    s_n        = 2'd0;
                    b_n        = 3'd0;
                end
            end
            S_ISSUE: next_state = S_WAIT;
            S_WAIT: begin
                if (i_bf_done) next_state = S_WRITE;
            end
            S_WRITE: begin
                if (b_q != 3'd7) begin
                    b_n        = b_q + 3'd1;
                    next_state = S_ISSUE;
                end else if (s_q != 2'd3) begin
                    s_n        = s_q + 2'd1;
                    b_n        = 3'd0;
                    next_state = S_ISSUE;
                end else begin
                    next_state = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                if (out_fire && out_idx == 4'd15) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_n = (next_state == S_IDLE) || (next_state == S_LOAD);
        busy_n     = (next_state == S_ISSUE) || (next_state == S_WAIT) ||
                     (next_state == S_WRITE);
        start_n    = (next_state == S_ISSUE);
        valid_n    = (next_state == S_UNLOAD);
        idx0_n     = calc_idx0(s_n, b_n);
        idx1_n     = idx0_n + (4'd1 << s_n);
        k_n        = calc_k(s_n, b_n);
        out_idx_n  = out_idx;
        if (state == S_WRITE) out_idx_n = 4'd0;
        else if (out_fire)    out_idx_n = out_idx + 4'd1;
    end

    // Next-pair reads never alias the pair being written back this edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_in_ready  <= 1'b0;
            o_busy      <= 1'b0;
            o_bf_start  <= 1'b0;
            o_out_valid <= 1'b0;
            o_bf_in0_re <= '0;
            o_bf_in0_im <= '0;
            o_bf_in1_re <= '0;
            o_bf_in1_im <= '0;
            o_bf_tw_re  <= '0;
            o_bf_tw_im  <= '0;
            o_out_re    <= '0;
            o_out_im    <= '0;
            in_cnt      <= '0;
            out_idx     <= '0;
            s_q         <= '0;
            b_q         <= '0;
            idx0_q      <= '0;
            idx1_q      <= '0;
            res0_re     <= '0;
            res0_im     <= '0;
            res1_re     <= '0;
            res1_im     <= '0;
        end else begin
            o_in_ready  <= in_ready_n;
            o_busy      <= busy_n;
            o_bf_start  <= start_n;
            o_out_valid <= valid_n;
            s_q         <= s_n;
            b_q         <= b_n;
            out_idx     <= out_idx_n;
            if (in_fire) in_cnt <= in_cnt + 4'd1;
            if (start_n) begin
                idx0_q <= idx0_n;
                idx1_q <= idx1_n;
                {o_bf_in0_re, o_bf_in0_im} <= mem[idx0_n];
                {o_bf_in1_re, o_bf_in1_im} <= mem[idx1_n];
                {o_bf_tw_re, o_bf_tw_im}   <= tw_rom(k_n);
            end
            if (state == S_WAIT && i_bf_done) begin
                res0_re <= i_bf_out0_re;
                res0_im <= i_bf_out0_im;
                res1_re <= i_bf_out1_re;
                res1_im <= i_bf_out1_im;
            end
            if (valid_n) {o_out_re, o_out_im} <= mem[out_idx_n];
        end
    end

    always_ff @(posedge i_clk) begin
        if (in_fire) mem[bitrev4(in_cnt)] <= {i_in_re, i_in_im};
        if (state == S_WRITE) begin
            mem[idx0_q] <= {scl(res0_re), scl(res0_im)};
            mem[idx1_q] <= {scl(res1_re), scl(res1_im)};
        end
    end

endmodule
